// File: rtl/junction_sequencer.sv
// Two-road junction phase sequencer: red, red+amber, green, amber with demand-driven switching.
// Define JUNCTION_PED_PHASE_EN to enable the pedestrian walk phase; without it ped_req_i is ignored.
module junction_sequencer #(
  parameter int RA_CYC     = 2,
  parameter int AMBER_CYC  = 3,
  parameter int ALLRED_CYC = 2,
  parameter int GREEN_MIN  = 4,
  parameter int GREEN_MAX  = 10,
  parameter int WALK_CYC   = 6
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       req_a_i,
  input  logic       req_b_i,
  input  logic       ped_req_i,
  output logic [2:0] lightsA_o,
  output logic [2:0] lightsB_o,
  output logic       walk_o
);

  typedef enum logic [2:0] {
    ALLRED = 3'd0,
    RA     = 3'd1,
    GREEN  = 3'd2,
    AMBER  = 3'd3,
    PED    = 3'd4
  } phase_e;

  localparam logic [7:0] RaLast       = 8'(RA_CYC - 1);
  localparam logic [7:0] AmberLast    = 8'(AMBER_CYC - 1);
  localparam logic [7:0] AllredLast   = 8'(ALLRED_CYC - 1);
  localparam logic [7:0] GreenMinLast = 8'(GREEN_MIN - 1);
  localparam logic [7:0] GreenMaxLast = 8'(GREEN_MAX - 1);
  localparam logic [7:0] WalkLast     = 8'(WALK_CYC - 1);

  phase_e     phase_q, phase_d;
  logic       road_q, road_d;
  logic [7:0] cnt_q, cnt_d;
  logic       pendA_q, pendA_d;
  logic       pendB_q, pendB_d;
  logic       pendP_q, pendP_d;

  logic       ownReq;
  logic       pendOther;
  logic       sw;
  logic [2:0] servedLights;

  // Road B is the reset road so the first clearance hands the junction to road A.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      phase_q <= ALLRED;
      road_q  <= 1'b1;
      cnt_q   <= '0;
      pendA_q <= 1'b0;
      pendB_q <= 1'b0;
      pendP_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      road_q  <= road_d;
      cnt_q   <= cnt_d;
      pendA_q <= pendA_d;
      pendB_q <= pendB_d;
      pendP_q <= pendP_d;
    end
  end

  always_comb begin
    ownReq    = road_q ? req_b_i : req_a_i;
    pendOther = road_q ? pendA_q : pendB_q;
`ifdef JUNCTION_PED_PHASE_EN
    sw        = pendOther | pendP_q;
`else
    sw        = pendOther;
`endif
    phase_d   = phase_q;
    road_d    = road_q;

    case (phase_q)
      ALLRED: begin
        if (cnt_q == AllredLast) begin
          if (pendP_q) begin
            phase_d = PED;
          end else begin
            road_d  = ~road_q;
            phase_d = RA;
          end
        end
      end
      RA: begin
        if (cnt_q == RaLast) phase_d = GREEN;
      end
      // Own-road demand extends green only until the maximum is reached.
      GREEN: begin
        if (sw && (cnt_q >= GreenMinLast) && (!ownReq || (cnt_q >= GreenMaxLast))) begin
          phase_d = AMBER;
        end
      end
      AMBER: begin
        if (cnt_q == AmberLast) phase_d = ALLRED;
      end
      PED: begin
        if (cnt_q == WalkLast) begin
          if (pendOther) road_d = ~road_q;
          phase_d = RA;
        end
      end
      default: phase_d = ALLRED;
    endcase

    if (phase_d != phase_q) begin
      cnt_d = '0;
    end else if (cnt_q == 8'hFF) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end

    // A flag clears on entry to its own green, winning over a same-cycle request.
    pendA_d = ((phase_d == GREEN) && !road_d) ? 1'b0 : (pendA_q | req_a_i);
    pendB_d = ((phase_d == GREEN) &&  road_d) ? 1'b0 : (pendB_q | req_b_i);
`ifdef JUNCTION_PED_PHASE_EN
    pendP_d = (phase_d == PED) ? 1'b0 : (pendP_q | ped_req_i);
`else
    pendP_d = 1'b0;
`endif
  end

`ifndef JUNCTION_PED_PHASE_EN
  logic unusedPedReq;
  assign unusedPedReq = ped_req_i;
`endif

  always_comb begin
    case (phase_q)
      RA:      servedLights = 3'b110;
      GREEN:   servedLights = 3'b001;
      AMBER:   servedLights = 3'b010;
      default: servedLights = 3'b100;
    endcase
    lightsA_o = road_q ? 3'b100 : servedLights;
    lightsB_o = road_q ? servedLights : 3'b100;
`ifdef JUNCTION_PED_PHASE_EN
    walk_o    = (phase_q == PED);
`else
    walk_o    = 1'b0;
`endif
  end

endmodule

// File: tb/tb_junction_sequencer.sv
// Testbench for junction_sequencer: directed scenarios with fixed timings plus randomized
// traffic, all compared every cycle against a duration-based behavioural model.
module tb_junction_sequencer;

  localparam int RA_CYC     = 2;
  localparam int AMBER_CYC  = 3;
  localparam int ALLRED_CYC = 2;
  localparam int GREEN_MIN  = 4;
  localparam int GREEN_MAX  = 10;
  localparam int WALK_CYC   = 6;

  localparam int P_ALLRED = 0;
  localparam int P_RA     = 1;
  localparam int P_GREEN  = 2;
  localparam int P_AMBER  = 3;
  localparam int P_PED    = 4;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       req_a_i = 1'b0;
  logic       req_b_i = 1'b0;
  logic       ped_req_i = 1'b0;
  logic [2:0] lightsA_o;
  logic [2:0] lightsB_o;
  logic       walk_o;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  int mPhase = P_ALLRED;
  int mRoad  = 1;
  int mAge   = 0;
  bit mPend[3];

  bit sawGreenA;
  bit sawGreenB;

  junction_sequencer #(
    .RA_CYC    (RA_CYC),
    .AMBER_CYC (AMBER_CYC),
    .ALLRED_CYC(ALLRED_CYC),
    .GREEN_MIN (GREEN_MIN),
    .GREEN_MAX (GREEN_MAX),
    .WALK_CYC  (WALK_CYC)
  ) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .req_a_i  (req_a_i),
    .req_b_i  (req_b_i),
    .ped_req_i(ped_req_i),
    .lightsA_o(lightsA_o),
    .lightsB_o(lightsB_o),
    .walk_o   (walk_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s at cycle %0d: observed %0h, expected %0h", tag, cyc, observed, expected);
    end
  endtask

  function automatic logic [2:0] roadLights(input int road);
    if (road != mRoad) return 3'b100;
    case (mPhase)
      P_RA:    return 3'b110;
      P_GREEN: return 3'b001;
      P_AMBER: return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  // Model tracks elapsed cycles per phase and compares them to the phase durations.
  task automatic modelStep(input bit ra, input bit rb, input bit rp, input bit rs);
    int np;
    int nr;
    bit wantSwitch;
    bit req[3];
    if (rs) begin
      mPhase = P_ALLRED;
      mRoad  = 1;
      mAge   = 0;
      for (int i = 0; i < 3; i++) mPend[i] = 1'b0;
      return;
    end
    req[0] = ra;
    req[1] = rb;
    req[2] = rp;
    np = mPhase;
    nr = mRoad;
    case (mPhase)
      P_ALLRED: if (mAge + 1 >= ALLRED_CYC) begin
        if (mPend[2]) np = P_PED;
        else begin
          np = P_RA;
          nr = 1 - mRoad;
        end
      end
      P_RA: if (mAge + 1 >= RA_CYC) np = P_GREEN;
      P_GREEN: begin
        wantSwitch = mPend[1 - mRoad] || mPend[2];
        if (wantSwitch && (mAge + 1 >= GREEN_MIN) && (!req[mRoad] || (mAge + 1 >= GREEN_MAX)))
          np = P_AMBER;
      end
      P_AMBER: if (mAge + 1 >= AMBER_CYC) np = P_ALLRED;
      P_PED: if (mAge + 1 >= WALK_CYC) begin
        np = P_RA;
        if (mPend[1 - mRoad]) nr = 1 - mRoad;
      end
      default: np = P_ALLRED;
    endcase
    mAge = (np != mPhase) ? 0 : mAge + 1;
    for (int r = 0; r < 2; r++) begin
      mPend[r] = (np == P_GREEN && nr == r) ? 1'b0 : (mPend[r] | req[r]);
    end
`ifdef JUNCTION_PED_PHASE_EN
    mPend[2] = (np == P_PED) ? 1'b0 : (mPend[2] | rp);
`else
    mPend[2] = 1'b0;
`endif
    mPhase = np;
    mRoad  = nr;
  endtask

  task automatic applyStimulus(input bit ra, input bit rb, input bit rp, input bit rs);
    req_a_i   = ra;
    req_b_i   = rb;
    ped_req_i = rp;
    rst_i     = rs;
    @(posedge clk_i);
    modelStep(ra, rb, rp, rs);
    @(negedge clk_i);
    cyc = rs ? 0 : cyc + 1;
    checkOutput("lightsA", {5'b0, lightsA_o}, {5'b0, roadLights(0)});
    checkOutput("lightsB", {5'b0, lightsB_o}, {5'b0, roadLights(1)});
    checkOutput("walk", {7'b0, walk_o}, {7'b0, (mPhase == P_PED)});
    checkOutput("bothNonRed", {7'b0, (lightsA_o != 3'b100) && (lightsB_o != 3'b100)}, 8'd0);
  endtask

  task automatic directed(input int when, input string tag, input logic [2:0] observed,
                          input logic [2:0] expected);
    if (cyc == when) checkOutput(tag, {5'b0, observed}, {5'b0, expected});
  endtask

  initial begin
    // Idle junction: A is served first and rests on green.
    applyStimulus(0, 0, 0, 1);
    directed(0, "s1_resetA", lightsA_o, 3'b100);
    directed(0, "s1_resetB", lightsB_o, 3'b100);
    directed(0, "s1_resetWalk", {2'b00, walk_o}, 3'b000);
    repeat (53) begin
      applyStimulus(0, 0, 0, 0);
      directed(1, "s1_allredA", lightsA_o, 3'b100);
      directed(2, "s1_raA", lightsA_o, 3'b110);
      directed(3, "s1_raA_end", lightsA_o, 3'b110);
      directed(4, "s1_greenA", lightsA_o, 3'b001);
      directed(53, "s1_holdA", lightsA_o, 3'b001);
      directed(53, "s1_holdB", lightsB_o, 3'b100);
    end

    // Single B pulse ends A green at the minimum.
    applyStimulus(0, 0, 0, 1);
    repeat (20) begin
      applyStimulus(0, cyc == 5, 0, 0);
      directed(7, "s2_greenA_end", lightsA_o, 3'b001);
      directed(8, "s2_amberA", lightsA_o, 3'b010);
      directed(10, "s2_amberA_end", lightsA_o, 3'b010);
      directed(11, "s2_allredA", lightsA_o, 3'b100);
      directed(13, "s2_raB", lightsB_o, 3'b110);
      directed(15, "s2_greenB", lightsB_o, 3'b001);
      directed(15, "s2_redA", lightsA_o, 3'b100);
    end

    // Own-road demand extends A green to the maximum.
    applyStimulus(1, 0, 0, 1);
    repeat (20) begin
      applyStimulus(1, cyc == 5, 0, 0);
      directed(13, "s3_greenA_ext", lightsA_o, 3'b001);
      directed(14, "s3_amberA", lightsA_o, 3'b010);
    end

    // Alternating demand on both roads.
    applyStimulus(0, 0, 0, 1);
    sawGreenA = 1'b0;
    sawGreenB = 1'b0;
    repeat (80) begin
      applyStimulus((cyc % 2) == 1, (cyc % 2) == 0, 0, 0);
      if (lightsA_o == 3'b001) sawGreenA = 1'b1;
      if (lightsB_o == 3'b001) sawGreenB = 1'b1;
    end
    checkOutput("s4_alternate", {7'b0, sawGreenA && sawGreenB}, 8'd1);

    // Pedestrian pulse.
    applyStimulus(0, 0, 0, 1);
    repeat (25) begin
      applyStimulus(0, 0, cyc == 5, 0);
`ifdef JUNCTION_PED_PHASE_EN
      directed(8, "s5_amberA", lightsA_o, 3'b010);
      directed(12, "s5_noWalkYet", {2'b00, walk_o}, 3'b000);
      directed(13, "s5_walkOn", {2'b00, walk_o}, 3'b001);
      directed(18, "s5_walkEnd", {2'b00, walk_o}, 3'b001);
      directed(19, "s5_raA", lightsA_o, 3'b110);
`else
      directed(13, "s5_noWalk", {2'b00, walk_o}, 3'b000);
      directed(20, "s5_stillGreenA", lightsA_o, 3'b001);
`endif
    end

    // Reset during B amber restarts the sequence.
    applyStimulus(0, 0, 0, 1);
    repeat (20) applyStimulus(cyc == 15, cyc == 5, 0, 0);
    directed(20, "s6_amberB", lightsB_o, 3'b010);
    applyStimulus(0, 0, 0, 1);
    directed(0, "s6_resetA", lightsA_o, 3'b100);
    directed(0, "s6_resetB", lightsB_o, 3'b100);
    directed(0, "s6_resetWalk", {2'b00, walk_o}, 3'b000);
    repeat (6) begin
      applyStimulus(0, 0, 0, 0);
      directed(2, "s6_raA", lightsA_o, 3'b110);
      directed(4, "s6_greenA", lightsA_o, 3'b001);
      directed(4, "s6_redB", lightsB_o, 3'b100);
    end

    // Randomized traffic with occasional resets.
    repeat (1500) begin
      applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 15) == 0, $urandom_range(0, 199) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/junction_sequencer.md
# junction_sequencer

Phase sequencer for a two-road junction. It drives the `lightsA` and `lightsB` 3-bit light buses with the standard sequence: red, red+amber, green, amber. It serves vehicle requests from both roads, enforces minimum green, extension and all-red clearance times, and can optionally insert a pedestrian walk phase. It replaces the free-running light counter wherever the junction must respond to sensors.

## Interface
- `RA_CYC`, 2: cycles of red+amber before green
- `AMBER_CYC`, 3: cycles of amber after green
- `ALLRED_CYC`, 2: cycles of all-red clearance
- `GREEN_MIN`, 4: minimum green cycles before a switch is allowed
- `GREEN_MAX`, 10: green cycles after which own-road extension stops
- `WALK_CYC`, 6: pedestrian walk cycles
- All parameters are 1..255 with `GREEN_MIN` ≤ `GREEN_MAX`. The phase counter `cnt` is 8 bits.
- `clk`, in, 1: clock
- `rst`, in, 1: reset. One clock; reset is synchronous and active-high.
- `req_a`, in, 1: vehicle present on road A (level)
- `req_b`, in, 1: vehicle present on road B (level)
- `ped_req`, in, 1: pedestrian button. The port exists in both builds and is ignored without the macro.
- `lightsA`, out, 3: road A lights, {red, amber, green}
- `lightsB`, out, 3: road B lights, {red, amber, green}
- `walk`, out, 1: pedestrian walk lamp

## Operation
- State register holds: `phase` ∈ {ALLRED, RA, GREEN, AMBER, PED}; `road` (0 = A, 1 = B, the road being served); `cnt`; and the pending flags `pend_a`, `pend_b`, `pend_p`.
- Outputs are Moore, decoded from `phase` and `road`:
  - Served road: RA → 110, GREEN → 001, AMBER → 010, ALLRED/PED → 100.
  - Unserved road: always 100.
  - `walk` = (`phase` == PED).
- `cnt` is cleared on every phase entry and increments each cycle, saturating at 255.
- Pending flags, per road x:
  - Next value = 0 if the next state is GREEN with `road` == x.
  - Otherwise next value = `pend_x` | `req_x`.
  - Clear wins over a simultaneous set.
- Transitions, evaluated at the end of a cycle:
  - ALLRED, when `cnt` == `ALLRED_CYC`-1: go to PED if `pend_p`; else toggle `road` and go to RA.
  - RA, when `cnt` == `RA_CYC`-1: go to GREEN.
  - GREEN exits to AMBER when all of the following hold:
    - `sw` is true, where `sw` = `pend_other` (| `pend_p` when the macro is defined);
    - `cnt` ≥ `GREEN_MIN`-1;
    - own-road `req` is low, or `cnt` ≥ `GREEN_MAX`-1.
  - GREEN with no `sw`: rests on green indefinitely.
  - AMBER, when `cnt` == `AMBER_CYC`-1: go to ALLRED.
  - PED, when `cnt` == `WALK_CYC`-1: toggle `road` if the other road's flag is pending; then go to RA.
- Reset:
  - `phase` = ALLRED, `road` = B, `cnt` = 0, all pending flags 0.
  - Outputs during reset: `lightsA` = `lightsB` = 100, `walk` = 0.
  - The first ALLRED exit toggles `road`, so road A is served first.
- Reset asserted mid-phase returns to the reset state on the next edge. No amber is completed.

## Timing
- Each phase lasts exactly its parameter in cycles. GREEN lasts at least `GREEN_MIN` cycles.
- A request latches one cycle after it is sampled and can end green no earlier than the `GREEN_MIN` boundary.
- From reset release with default parameters:
  - ALLRED: cycles 0–1
  - A RA: cycles 2–3
  - A GREEN: from cycle 4
- Both roads never show anything other than red at the same time. ALLRED or PED always separates an AMBER from the next RA.
- A 1-cycle request pulse is never lost.

## Configuration
- `JUNCTION_PED_PHASE_EN`, defined:
  - `pend_p` is latched from `ped_req` and cleared on PED entry (clear wins).
  - `pend_p` can end green and forces PED after ALLRED.
- Not defined:
  - `pend_p` is held 0 and the PED phase is unreachable.
  - `walk` is tied 0 and `ped_req` is ignored.

## Test plan
- Reset, no requests → ALLRED at cycles 0–1, A RA (110/100) at cycles 2–3, then A GREEN (001/100) held for 50 cycles.
- 1-cycle `req_b` pulse at cycle 5 → A GREEN at cycles 4–7, A AMBER at 8–10, ALLRED at 11–12, B RA at 13–14, B GREEN (100/001) at 15.
- `req_b` at cycle 5 with `req_a` held high → A GREEN is extended to cycles 4–13 (`GREEN_MAX`), AMBER starts at cycle 14.
- `req_a` and `req_b` toggling every cycle → no cycle with both roads non-red, and roads alternate.
- With the macro: `ped_req` pulse at cycle 5, no vehicles → A AMBER at 8–10, ALLRED at 11–12, PED with `walk` = 1 at 13–18, A RA at 19–20. Without the macro: A remains green and `walk` stays 0.
- `rst` asserted during B AMBER → next cycle shows 100/100, `walk` = 0, and the sequence restarts as in the first scenario.
